// File: rtl/jt12_sh_slot.sv
// jt12_sh_slot
//   Slot-indexed shift register: a chain of `stages` registers, each `width`
//   bits wide, advanced on clock-enabled edges. A slot counter tracks which
//   revolution position is being written into stage 0, so the value leaving
//   on `drop` while slot==s is the value written at slot s one revolution ago.
//
// Parameters
//   width   bit width of each stage
//   stages  delay depth in slots (1..64)
//   rstval  reset value of every stage (truncated to width LSBs)
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   cen      in   clock enable; state only advances when high
//   hold     in   recirculate drop into stage 0 instead of din
//   din      in   [width] data into stage 0
//   drop     out  [width] last stage contents
//   slot     out  [SW] current slot index, SW = max(1, clog2(stages))
//   zero     out  high while slot == 0
//
// Optional feature (macro JT12_SH_TAP_EN)
//   tap_sel  in   [SW] stage index to observe
//   tap      out  [width] stage[tap_sel], 0 when tap_sel >= stages
module jt12_sh_slot #(
  parameter int width  = 5,
  parameter int stages = 24,
  parameter int rstval = 0,
  localparam int SW    = (stages > 1) ? $clog2(stages) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             hold,
  input  logic [width-1:0] din,
  output logic [width-1:0] drop,
  output logic [SW-1:0]    slot,
  output logic             zero
`ifdef JT12_SH_TAP_EN
  ,
  input  logic [SW-1:0]    tap_sel,
  output logic [width-1:0] tap
`endif
);

  localparam logic [width-1:0] RSTV = width'(rstval);
  localparam logic [SW-1:0]    LAST = SW'(stages - 1);

  logic [width-1:0] r_stage [stages];
  logic [SW-1:0]    r_slot;
  logic [width-1:0] w_feed;

  // hold wins over din so a recirculating ring never picks up new data
  assign w_feed = hold ? r_stage[stages-1] : din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < stages; k++) r_stage[k] <= RSTV;
    end else if (cen) begin
      r_stage[0] <= w_feed;
      for (int k = 1; k < stages; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
    end else if (cen) begin
      r_slot <= (r_slot == LAST) ? '0 : r_slot + 1'b1;
    end
  end

  assign drop = r_stage[stages-1];
  assign slot = r_slot;
  assign zero = (r_slot == '0);

`ifdef JT12_SH_TAP_EN
  always_comb begin
    tap = '0;
    if (int'(tap_sel) < stages) tap = r_stage[tap_sel];
  end
`endif

endmodule

// File: tb/tb_jt12_sh_slot.sv
module tb_jt12_sh_slot;

  localparam int W0 = 5;
  localparam int S0 = 24;
  localparam int R0 = 'h15;
  localparam int W1 = 8;
  localparam int R1 = 'h3C;

  logic          clk;
  logic          rst_n;
  logic          cen;
  logic          hold;
  logic [W0-1:0] din;
  logic [W0-1:0] drop;
  logic [4:0]    slot;
  logic          zero;
  logic [W1-1:0] din1;
  logic [W1-1:0] drop1;
  logic          slot1;
  logic          zero1;
`ifdef JT12_SH_TAP_EN
  logic [4:0]    tap_sel;
  logic [W0-1:0] tap;
  logic          tap_sel1;
  logic [W1-1:0] tap1;
`endif

  jt12_sh_slot #(.width(W0), .stages(S0), .rstval(R0)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .hold(hold), .din(din),
    .drop(drop), .slot(slot), .zero(zero)
`ifdef JT12_SH_TAP_EN
    , .tap_sel(tap_sel), .tap(tap)
`endif
  );

  jt12_sh_slot #(.width(W1), .stages(1), .rstval(R1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .hold(hold), .din(din1),
    .drop(drop1), .slot(slot1), .zero(zero1)
`ifdef JT12_SH_TAP_EN
    , .tap_sel(tap_sel1), .tap(tap1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int drop;
    int slot;
    int zero;
    int drop1;
    int slot1;
    int zero1;
    int tap;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: a FIFO of the values written to the line. Front is the
  // oldest entry (what drop shows), back is the newest (stage 0).
  int m_line[$];
  int m_line1;
  int m_edges;

  function automatic exp_t model_out();
    exp_t e;
    int   ts;
    e.drop  = m_line[0];
    e.slot  = m_edges % S0;
    e.zero  = (e.slot == 0) ? 1 : 0;
    e.drop1 = m_line1;
    e.slot1 = 0;
    e.zero1 = 1;
    e.tap   = 0;
`ifdef JT12_SH_TAP_EN
    ts = int'(tap_sel);
    if (ts < S0) e.tap = m_line[S0-1-ts];
`else
    ts = 0;
    e.tap = ts;
`endif
    return e;
  endfunction

  initial begin
    int nv;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_line.delete();
        for (int k = 0; k < S0; k++) m_line.push_back(R0 & 'h1F);
        m_line1 = R1 & 'hFF;
        m_edges = 0;
      end else begin
        if (cen) begin
          nv = hold ? m_line[0] : int'(din);
          void'(m_line.pop_front());
          m_line.push_back(nv);
          m_line1 = hold ? m_line1 : int'(din1);
          m_edges = m_edges + 1;
        end
        sb.push_back(model_out());
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: after every edge or reset assertion, compare DUT outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (!rst_n) begin
        chk("rst_drop",  int'(drop),  R0);
        chk("rst_slot",  int'(slot),  0);
        chk("rst_zero",  int'(zero),  1);
        chk("rst_drop1", int'(drop1), R1);
        chk("rst_zero1", int'(zero1), 1);
      end else if (sb.size() == 0) begin
        chk("sb_empty", 0, 1);
      end else begin
        e = sb.pop_front();
        chk("drop",  int'(drop),  e.drop);
        chk("slot",  int'(slot),  e.slot);
        chk("zero",  int'(zero),  e.zero);
        chk("drop1", int'(drop1), e.drop1);
        chk("slot1", int'(slot1), e.slot1);
        chk("zero1", int'(zero1), e.zero1);
`ifdef JT12_SH_TAP_EN
        chk("tap",   int'(tap),   e.tap);
`endif
      end
    end
  end

  task automatic step(input logic c, input logic h, input int d, input int d1);
    @(negedge clk);
    cen  = c;
    hold = h;
    din  = W0'(d);
    din1 = W1'(d1);
  endtask

  initial begin
    rst_n = 1'b0;
    cen   = 1'b0;
    hold  = 1'b0;
    din   = '0;
    din1  = '0;
`ifdef JT12_SH_TAP_EN
    tap_sel  = 5'd3;
    tap_sel1 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // load slot indices 0..23
    for (int i = 0; i < S0; i++) step(1'b1, 1'b0, i, 'hA5);
    // recirculate two full revolutions with din=31
    for (int i = 0; i < 2*S0; i++) step(1'b1, 1'b1, 31, $urandom_range(0, 255));
`ifdef JT12_SH_TAP_EN
    @(negedge clk);
    tap_sel = 5'd30;
`endif
    // cen pattern 1,0,0,1 with counting din
    for (int i = 0; i < 48; i++)
      step((i % 4 == 0) || (i % 4 == 3), 1'b0, i, i * 7);
    // random traffic
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom), 1'($urandom_range(0, 3) == 0), $urandom_range(0, 31), $urandom_range(0, 255));
`ifdef JT12_SH_TAP_EN
      tap_sel = 5'($urandom_range(0, 31));
`endif
    end
    // asynchronous reset between edges
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // fresh data after reset, then more random traffic
    for (int i = 0; i < S0 + 4; i++) step(1'b1, 1'b0, (i + 9) % 32, i + 1);
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom), 1'($urandom_range(0, 3) == 0), $urandom_range(0, 31), $urandom_range(0, 255));
`ifdef JT12_SH_TAP_EN
      tap_sel = 5'($urandom_range(0, 31));
`endif
    end
    step(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
